score_bcd_counter: RTL and testbench
====================================

# score_bcd_counter

Four-digit BCD score accumulator for the bat-shooter game. It sits directly upstream of the four seven-segment hex decoders: each 4-bit digit output drives one decoder's `S` input. The game logic sends it hit events with a point value. It tracks game phase, saturates at 9999, and can optionally keep a session high score.

## Interface
Parameters:
- `MAX_DIGIT`, default 9: largest legal per-hit point value; larger inputs are clamped to it.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `resetn`  input  1  asynchronous, active-low reset.
- `start`  input  1  single-cycle pulse that begins a game.
- `hit`  input  1  single-cycle pulse; one scoring event.
- `points`  input  4  binary point value for `hit`; 0–15, clamped to `MAX_DIGIT`.
- `game_over`  input  1  single-cycle pulse that ends the game.
- `show_high`  input  1  digit outputs show the high score instead of the live score (macro-dependent).
- `digit0`..`digit3`  output  4 each  BCD digits, ones to thousands; each feeds one hex decoder.
- `playing`  output  1  high in PLAY state.
- `saturated`  output  1  live score equals 9999.
- `new_high`  output  1  set when the last game beat the high score; cleared by `start`.

## Operation
- States: IDLE (reset state), PLAY, OVER.
- IDLE or OVER, on `start`:
  - go to PLAY;
  - score ← 0000;
  - `new_high` ← 0.
- PLAY, on `hit`:
  - score ← score + min(`points`, `MAX_DIGIT`), as a 4-digit BCD add with decimal carry ripple within one cycle;
  - if the sum exceeds 9999, score ← 9999 (saturate, no wrap).
- PLAY, on `game_over`: go to OVER. Score is frozen.
- `hit` in IDLE or OVER: ignored.
- `game_over` outside PLAY: ignored.
- `start` in PLAY: restarts the game. Score is cleared and state stays PLAY.
- Simultaneous events in one cycle, priority `start` > `game_over` > `hit`:
  - a `hit` that coincides with `game_over` is dropped;
  - a `hit` that coincides with `start` is dropped.
- `points` = 0 with `hit`: score unchanged and no error.
- Each digit register only ever holds 0–9; values 10–15 are unreachable.

## Timing
- Reset values (asserted asynchronously): state IDLE, all digits 0, `playing` 0, `saturated` 0, `new_high` 0, high score 0000.
- Latency is 1 cycle:
  - a `hit` sampled at edge n appears on the digit outputs after edge n;
  - a `game_over` sampled at edge n clears `playing` after edge n.
- Throughput: one `hit` per cycle, back-to-back. No handshake; the block is always ready.
- `show_high` is a combinational output mux with 0-cycle effect. The registers are not affected.
- `saturated` is registered and is valid in the same cycle as the digits it describes.
- Reset mid-game: all state returns to reset values immediately, including the high score.

## Configuration
- Macro `SCORE_HIGH_SCORE_EN`.
- Defined:
  - a 16-bit BCD high-score register exists;
  - on the PLAY→OVER transition, if score > high (BCD magnitude compare), high ← score and `new_high` ← 1, on the same edge;
  - `show_high` = 1 drives the high score onto the digits.
- Undefined:
  - no high-score register;
  - `show_high` is ignored and the digits always show the live score;
  - `new_high` is tied to 0.

## Structure
- Shared package/header holds:
  - state encodings `ST_IDLE`=2'd0, `ST_PLAY`=2'd1, `ST_OVER`=2'd2;
  - `BCD_MAX_SCORE` = 16'h9999;
  - the digit width constant 4.
- Sub-module `bcd_digit_add`: one decade adder, 4-bit a, 4-bit b, carry-in → 4-bit sum, carry-out. Instantiated four times as a ripple chain. The carry-out of the thousands stage triggers saturation.
- Top level contains the FSM, score register, high-score logic under the macro, and the output mux.

## Test plan
- Reset then `start`, then three hits with `points` = 7, 5, 9 → digits 0,0,0,7 → 0,0,1,2 → 0,0,2,1 (thousands..ones), with 1-cycle latency each.
- Score 9995, `hit` with `points` = 9 → 9999 and `saturated` = 1. A further `hit` with `points` = 3 → 9999 again.
- `hit` with `points` = 15 from 0000 → 0009 (clamped).
- `game_over` and `hit` in the same cycle at score 0040 → state OVER, score stays 0040. Later hits are ignored.
- With macro defined:
  - game 1 ends at 0120 → `new_high` = 1;
  - game 2 ends at 0080 → `new_high` = 0 and the high score stays 0120;
  - `show_high` = 1 → digits 0,1,2,0.
- `resetn` asserted mid-game at score 0333 → all outputs 0 asynchronously. After release, state is IDLE and hits are ignored until `start`.

Source files
------------

// File: rtl/score_bcd_counter_pkg.sv
// Shared definitions for the four-digit BCD score accumulator.
//   state_t        : game phase encodings (IDLE / PLAY / OVER)
//   BCD_MAX_SCORE  : packed-BCD saturation value 9999
//   DIGIT_W        : width of one BCD digit
package score_bcd_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    localparam logic [15:0] BCD_MAX_SCORE = 16'h9999;
    localparam int unsigned DIGIT_W       = 4;

endpackage

// File: rtl/score_bcd_counter_bcd_digit_add.sv
// One decade (BCD digit) adder stage.
//   a, b : BCD digit operands (0-9)
//   cin  : decimal carry from the next lower digit
//   sum  : BCD result digit (0-9)
//   cout : decimal carry to the next higher digit
module bcd_digit_add
    import score_bcd_counter_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               cin,
    output logic [DIGIT_W-1:0] sum,
    output logic               cout
);

    logic [DIGIT_W:0] raw;
    logic [DIGIT_W:0] adj;

    always_comb begin
        raw = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, cin};
        // Binary sums above 9 are folded back into decimal by adding 6.
        if (raw > 5'd9) begin
            adj  = raw + 5'd6;
            cout = 1'b1;
        end else begin
            adj  = raw;
            cout = 1'b0;
        end
        sum = adj[DIGIT_W-1:0];
    end

endmodule

// File: rtl/score_bcd_counter.sv
// Four-digit BCD score accumulator for the bat-shooter game.
// Optional feature macro: SCORE_HIGH_SCORE_EN (session high score).
//   clk        : system clock, rising edge
//   resetn     : asynchronous active-low reset
//   start      : pulse, begins (or restarts) a game
//   hit        : pulse, adds min(points, MAX_DIGIT) to the score in PLAY
//   points     : binary point value for hit
//   game_over  : pulse, ends the game in PLAY
//   show_high  : show the high score on the digits (macro build only)
//   digit0..3  : BCD digits, ones to thousands
//   playing    : high in PLAY
//   saturated  : live score equals 9999
//   new_high   : last game beat the high score; cleared by start
module score_bcd_counter
    import score_bcd_counter_pkg::*;
#(
    parameter int MAX_DIGIT = 9
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       hit,
    input  logic [3:0] points,
    input  logic       game_over,
    input  logic       show_high,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic       playing,
    output logic       saturated,
    output logic       new_high
);

    localparam logic [3:0] MAX_PTS = 4'(MAX_DIGIT);

    state_t      state_q, state_d;
    logic [15:0] score_q, score_d;
    logic [15:0] sum;
    logic [4:0]  carry;
    logic [3:0]  pts;
    logic        sat_q;
    logic        finish;
    logic [15:0] display;

    assign pts      = (points > MAX_PTS) ? MAX_PTS : points;
    assign carry[0] = 1'b0;

    // Ripple chain: the clamped point value enters at the ones digit,
    // higher digits only absorb the decimal carry.
    for (genvar i = 0; i < 4; i++) begin : g_add
        bcd_digit_add u_add (
            .a    (score_q[i*DIGIT_W +: DIGIT_W]),
            .b    ((i == 0) ? pts : 4'd0),
            .cin  (carry[i]),
            .sum  (sum[i*DIGIT_W +: DIGIT_W]),
            .cout (carry[i+1])
        );
    end

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        finish  = 1'b0;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_d = ST_PLAY;
                    score_d = '0;
                end
            end
            ST_PLAY: begin
                if (start) begin
                    score_d = '0;
                end else if (game_over) begin
                    state_d = ST_OVER;
                    finish  = 1'b1;
                end else if (hit) begin
                    // Carry out of the thousands digit means the sum passed 9999.
                    score_d = carry[4] ? BCD_MAX_SCORE : sum;
                end
            end
            default: begin
                state_d = ST_IDLE;
                score_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            score_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            sat_q   <= (score_d == BCD_MAX_SCORE);
        end
    end

`ifdef SCORE_HIGH_SCORE_EN
    logic [15:0] high_q;
    logic        new_high_q;

    // Packed BCD digits order the same way as plain binary, so a 16-bit
    // unsigned compare is a correct decimal magnitude compare.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            high_q     <= '0;
            new_high_q <= 1'b0;
        end else if (start) begin
            new_high_q <= 1'b0;
        end else if (finish && (score_q > high_q)) begin
            high_q     <= score_q;
            new_high_q <= 1'b1;
        end
    end

    assign display  = show_high ? high_q : score_q;
    assign new_high = new_high_q;
`else
    logic unused_show_high;
    logic unused_finish;

    assign unused_show_high = show_high;
    assign unused_finish    = finish;
    assign display          = score_q;
    assign new_high         = 1'b0;
`endif

    assign digit0    = display[3:0];
    assign digit1    = display[7:4];
    assign digit2    = display[11:8];
    assign digit3    = display[15:12];
    assign playing   = (state_q == ST_PLAY);
    assign saturated = sat_q;

endmodule

// File: tb/tb_score_bcd_counter.sv
// Self-checking bench for score_bcd_counter: directed scenarios plus
// randomized events, all checked against a decimal reference model.
module tb_score_bcd_counter;

    logic       clk;
    logic       resetn;
    logic       start;
    logic       hit;
    logic [3:0] points;
    logic       game_over;
    logic       show_high;
    logic [3:0] digit0, digit1, digit2, digit3;
    logic       playing;
    logic       saturated;
    logic       new_high;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: plain decimal integers and a phase number.
    int m_phase;     // 0 idle, 1 play, 2 over
    int m_score;
    int m_high;
    int m_new_high;

`ifdef SCORE_HIGH_SCORE_EN
    localparam bit HS = 1'b1;
`else
    localparam bit HS = 1'b0;
`endif

    score_bcd_counter #(.MAX_DIGIT(9)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .hit       (hit),
        .points    (points),
        .game_over (game_over),
        .show_high (show_high),
        .digit0    (digit0),
        .digit1    (digit1),
        .digit2    (digit2),
        .digit3    (digit3),
        .playing   (playing),
        .saturated (saturated),
        .new_high  (new_high)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase    = 0;
        m_score    = 0;
        m_high     = 0;
        m_new_high = 0;
    endtask

    task automatic model_step(input bit s, input bit h, input int p, input bit g);
        int add;
        add = (p > 9) ? 9 : p;
        if (s) begin
            m_phase    = 1;
            m_score    = 0;
            m_new_high = 0;
        end else if (m_phase == 1 && g) begin
            m_phase = 2;
            if (HS && m_score > m_high) begin
                m_high     = m_score;
                m_new_high = 1;
            end
        end else if (m_phase == 1 && h) begin
            m_score = m_score + add;
            if (m_score > 9999) m_score = 9999;
        end
    endtask

    task automatic check_all(input string tag);
        int disp;
        disp = (HS && show_high) ? m_high : m_score;
        check_val({tag, ".d0"}, int'(digit0), disp % 10);
        check_val({tag, ".d1"}, int'(digit1), (disp / 10) % 10);
        check_val({tag, ".d2"}, int'(digit2), (disp / 100) % 10);
        check_val({tag, ".d3"}, int'(digit3), (disp / 1000) % 10);
        check_val({tag, ".playing"}, int'(playing), (m_phase == 1) ? 1 : 0);
        check_val({tag, ".saturated"}, int'(saturated), (m_score == 9999) ? 1 : 0);
        check_val({tag, ".new_high"}, int'(new_high), HS ? m_new_high : 0);
    endtask

    task automatic step(input string tag, input bit s, input bit h,
                        input logic [3:0] p, input bit g);
        start     = s;
        hit       = h;
        points    = p;
        game_over = g;
        @(posedge clk);
        model_step(s, h, int'(p), g);
        #1;
        check_all(tag);
        start     = 1'b0;
        hit       = 1'b0;
        game_over = 1'b0;
    endtask

    initial begin
        resetn    = 1'b0;
        start     = 1'b0;
        hit       = 1'b0;
        points    = 4'd0;
        game_over = 1'b0;
        show_high = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        resetn = 1'b1;

        // Basic accumulation 7, 5, 9.
        step("start", 1, 0, 4'd0, 0);
        step("hit7", 0, 1, 4'd7, 0);
        step("hit5", 0, 1, 4'd5, 0);
        step("hit9", 0, 1, 4'd9, 0);
        check_val("sum21", int'({digit1, digit0}), int'(8'h21));

        // Clamp of out-of-range points.
        step("restart", 1, 1, 4'd9, 0);
        step("clamp15", 0, 1, 4'd15, 0);
        step("pts0", 0, 1, 4'd0, 0);

        // game_over with coincident hit at 0040, later hits ignored.
        step("start40", 1, 0, 4'd0, 0);
        repeat (4) step("to40", 0, 1, 4'd9, 0);
        step("to40", 0, 1, 4'd4, 0);
        step("over_hit", 0, 1, 4'd9, 1);
        step("over_ign", 0, 1, 4'd9, 0);
        step("over_go", 0, 0, 4'd0, 1);

        // Saturation at 9999.
        step("start_sat", 1, 0, 4'd0, 0);
        repeat (1110) step("climb", 0, 1, 4'd9, 0);
        step("to9995", 0, 1, 4'd5, 0);
        step("sat9", 0, 1, 4'd9, 0);
        step("sat3", 0, 1, 4'd3, 0);
        step("sat_over", 0, 0, 4'd0, 1);

`ifdef SCORE_HIGH_SCORE_EN
        // Game 1 ends at 0120 (beats 9999? no: reset high first).
        resetn = 1'b0;
        #1;
        model_reset();
        check_all("hs_reset");
        @(negedge clk);
        resetn = 1'b1;
        step("g1", 1, 0, 4'd0, 0);
        repeat (12) step("g1hit", 0, 1, 4'd9, 0);
        step("g1hit", 0, 1, 4'd12, 0);
        step("g1hit", 0, 1, 4'd3, 0);
        step("g1end", 0, 0, 4'd0, 1);
        step("g2", 1, 0, 4'd0, 0);
        repeat (8) step("g2hit", 0, 1, 4'd9, 0);
        step("g2hit", 0, 1, 4'd8, 0);
        step("g2end", 0, 0, 4'd0, 1);
        show_high = 1'b1;
        #1;
        check_all("show_high");
        check_val("show_high.raw", int'({digit3, digit2, digit1, digit0}), int'(16'h0120));
        show_high = 1'b0;
        #1;
        check_all("show_live");
`endif

        // Asynchronous reset mid-game at 0333.
        @(negedge clk);
        step("rst_game", 1, 0, 4'd0, 0);
        repeat (37) step("to333", 0, 1, 4'd9, 0);
        repeat (3) step("to333", 0, 1, 4'd0, 0);
        check_val("score333", int'({digit2, digit1, digit0}), int'(12'h333));
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        resetn = 1'b1;
        step("idle_hit", 0, 1, 4'd9, 0);
        step("idle_go", 0, 1, 4'd9, 1);

        // Randomized event stream.
        for (int i = 0; i < 4000; i++) begin
            bit s, h, g;
            s = ($urandom_range(0, 99) < 3);
            g = ($urandom_range(0, 99) < 3);
            h = ($urandom_range(0, 99) < 70);
            show_high = $urandom_range(0, 1) != 0;
            step("rand", s, h, 4'($urandom_range(0, 15)), g);
        end
        show_high = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
